cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Schedules the single Common Data Bus among result producers in the out-of-order core.
- Producers are three ALU reservation stations (requesters 0-2) and the load/store buffer (requester 3).
- Grants one producer per cycle and registers the winner's ROB tag and result onto the CDB.
- The CDB drives issue control, the reservation stations, the load/store buffer, the ROB and the regfile.
- Round-robin arbitration, with a bounded load/store priority boost so memory results do not queue behind ALU bursts.

Parameters:
- NUM_REQ, 4, number of requesters; index NUM_REQ-1 is the load/store buffer.
- data_width, 16, result width.
- tag_width, 3, ROB tag width.
- LDST_PRIO, 1, 1 = load/store buffer has fixed priority subject to LDST_LIMIT; 0 = pure round-robin.
- LDST_LIMIT, 2, maximum consecutive load/store grants while any other requester is waiting.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  mispredict flush; discards pending and registered broadcast.
- req  input  NUM_REQ  per-requester result-ready request.
- req_tag  input  NUM_REQ*tag_width  ROB tag for each requester, packed, requester i at [i*tag_width +: tag_width].
- req_data  input  NUM_REQ*data_width  result for each requester, packed likewise.
- grant  output  NUM_REQ  one-hot grant, combinational, same cycle as req.
- cdb_out  output  CDB (1+tag_width+data_width)  registered broadcast {valid, tag, data}.
- ldst_streak  output  2  current consecutive load/store grant count, for debug.

Behaviour:
- Reset: cdb_out.valid=0, tag=0, data=0; rr_ptr=0; ldst_streak=0; grant=0 while reset is high. Reset mid-stream drops any in-flight broadcast.
- Handshake: requester holds req, tag and data stable until it sees grant[i]=1 in the same cycle. It deasserts req (or presents its next result) on the following cycle. Arbiter never grants a requester whose req=0.
- Grant is combinational, at most one bit set, and is 0 when req==0 or flush=1.
- Winner selection, LDST_PRIO=1:
  - If req[NUM_REQ-1]=1 and (ldst_streak<LDST_LIMIT or no other req set), grant load/store.
  - Otherwise grant the first set req[i] scanning i = rr_ptr, rr_ptr+1, ... modulo NUM_REQ-1, over ALU requesters only.
- Winner selection, LDST_PRIO=0: scan all NUM_REQ requesters from rr_ptr modulo NUM_REQ.
- rr_ptr update (posedge, when an ALU requester k is granted): rr_ptr <= k+1, wrapping. Unchanged otherwise.
- ldst_streak update:
  - increments (saturating at 3) on a load/store grant while another req is set;
  - resets to 0 on any ALU grant;
  - resets to 0 on a load/store grant with no competitor.
- Latency: broadcast appears exactly 1 cycle after grant. cdb_out <= {1, req_tag[w], req_data[w]} when any grant, else valid <= 0. Tag and data hold their last values when valid=0.
- Throughput: one broadcast per cycle. Back-to-back grants to different requesters are allowed.
- flush=1:
  - grant forced to 0;
  - next-cycle cdb_out.valid=0;
  - rr_ptr and ldst_streak reset to 0.
  - Requesters are themselves flushed, so no re-request is expected.
- Simultaneous reset and flush: reset dominates; the result is identical.
- ROB-side write-back consumes cdb_out.valid/tag; the arbiter never checks tag uniqueness.

Decomposition:
- lc3b_types package: reuse the existing CDB struct (valid, tag, data) and lc3b_rob_addr.
- Add constant LDST_REQ_IDX = NUM_REQ-1 to the package.
- One sub-module: rr_pick, a combinational round-robin priority encoder. Inputs: request vector and start pointer. Outputs: one-hot grant and found flag. Reused by the ALU-only and full scans.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> grant=0, cdb_out.valid=0, rr_ptr=0.
- req=4'b0111, tags 1/2/3, data 16'h0011/16'h0022/16'h0033, each dropped after its grant -> grants 0,1,2 on consecutive cycles. cdb_out shows tag 1/2/3 one cycle later with matching data.
- LDST_PRIO=1, LDST_LIMIT=2, req[3] held with a new tag every cycle, req[0] held with tag 5 data 16'hBEEF:
  - grants 3,3,0,3,3,0...;
  - ldst_streak sequence 1,2,0;
  - tag 5/16'hBEEF broadcast on cycle 4.
- Only req[3] set for 6 cycles -> granted every cycle; ldst_streak stays 0; valid=1 each following cycle.
- Grant to requester 1 at cycle N, flush asserted at cycle N+1 with req=4'b1101 -> grant=0 at N+1, cdb_out.valid=0 at N+2, rr_ptr=0.
- Reset asserted while cdb_out.valid=1 -> valid=0 next cycle and all outputs at reset values; no grant during reset despite req=4'b1111.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and constants for the result-broadcast arbiter.
//   lc3b_rob_addr : ROB tag carried on the CDB
//   lc3b_word     : result word carried on the CDB
//   cdb_t         : registered broadcast {valid, tag, data}
//   LDST_REQ_IDX  : requester index of the load/store buffer
package cdb_arbiter_pkg;

    localparam int NUM_REQ      = 4;
    localparam int LDST_REQ_IDX = NUM_REQ - 1;
    localparam int TAG_W        = 3;
    localparam int DATA_W       = 16;

    typedef logic [TAG_W-1:0]  lc3b_rob_addr;
    typedef logic [DATA_W-1:0] lc3b_word;

    typedef struct packed {
        logic         valid;
        lc3b_rob_addr tag;
        lc3b_word     data;
    } cdb_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer <-> arbiter bundle for the Common Data Bus.
//   flush       : mispredict flush
//   req         : per-requester result-ready
//   req_tag     : packed ROB tags, requester i at [i*tag_width +: tag_width]
//   req_data    : packed results, requester i at [i*data_width +: data_width]
//   grant       : one-hot combinational grant
//   cdb_out     : registered broadcast
//   ldst_streak : consecutive load/store grant count (debug)
// master = producer/control side, slave = arbiter.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int tag_width  = 3,
    parameter int data_width = 16
);
    logic                          flush;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*tag_width-1:0]  req_tag;
    logic [NUM_REQ*data_width-1:0] req_data;
    logic [NUM_REQ-1:0]            grant;
    cdb_t                          cdb_out;
    logic [1:0]                    ldst_streak;

    modport master (
        output flush, req, req_tag, req_data,
        input  grant, cdb_out, ldst_streak
    );

    modport slave (
        input  flush, req, req_tag, req_data,
        output grant, cdb_out, ldst_streak
    );
endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin priority encoder.
//   req   : request vector (N bits)
//   start : index scanned first; scan continues start+1, ... modulo N
//   gnt   : one-hot grant of the first set request found
//   found : any request set
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic          found
);
    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(start) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: picks one result producer per cycle and
// registers its ROB tag and result onto the CDB one cycle later.
//   clk, reset : clock, synchronous active-high reset
//   bus        : producer bundle (flush, req, req_tag, req_data in;
//                grant, cdb_out, ldst_streak out)
// Requesters 0..NUM_REQ-2 are ALU stations, NUM_REQ-1 is the load/store
// buffer. With LDST_PRIO=1 the load/store buffer wins outright until it
// has taken LDST_LIMIT consecutive grants over a waiting ALU requester,
// then one ALU requester gets through round-robin.
// tag_width/data_width must match the cdb_t field widths in the package.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int data_width = 16,
    parameter int tag_width  = 3,
    parameter int LDST_PRIO  = 1,
    parameter int LDST_LIMIT = 2
) (
    input  logic          clk,
    input  logic          reset,
    cdb_arbiter_if.slave  bus
);
    localparam int PW      = $clog2(NUM_REQ);
    localparam int NALU    = NUM_REQ - 1;
    localparam int LDST    = NUM_REQ - 1;
    // Last pointer value before wrapping: ALU-only scan in boost mode.
    localparam int RR_WRAP = (LDST_PRIO != 0) ? NALU - 1 : NUM_REQ - 1;

    logic [PW-1:0]         rr_ptr;
    logic [1:0]            streak;
    cdb_t                  cdb_q;

    logic [NALU-1:0]       alu_gnt;
    logic                  alu_found;
    logic [NUM_REQ-1:0]    all_gnt;
    logic                  all_found;

    logic [NUM_REQ-1:0]    gnt;
    logic                  others;
    logic                  boost;
    logic                  rr_adv;
    logic [PW-1:0]         win_idx;
    logic [tag_width-1:0]  win_tag;
    logic [data_width-1:0] win_data;

    rr_pick #(.N(NALU), .PW(PW)) u_alu_pick (
        .req   (bus.req[NALU-1:0]),
        .start (rr_ptr),
        .gnt   (alu_gnt),
        .found (alu_found)
    );

    rr_pick #(.N(NUM_REQ), .PW(PW)) u_all_pick (
        .req   (bus.req),
        .start (rr_ptr),
        .gnt   (all_gnt),
        .found (all_found)
    );

    always_comb begin
        others = |bus.req[NALU-1:0];
        // Load/store keeps winning while under its streak budget, or
        // whenever nobody else is waiting.
        boost  = bus.req[LDST] && ((32'(streak) < LDST_LIMIT) || !others);
        gnt    = '0;
        if (!reset && !bus.flush) begin
            if (LDST_PRIO != 0) begin
                if (boost)          gnt[LDST]      = 1'b1;
                else if (alu_found) gnt[NALU-1:0]  = alu_gnt;
            end else if (all_found) begin
                gnt = all_gnt;
            end
        end
    end

    // One-hot grant -> winner index and payload.
    always_comb begin
        win_idx  = '0;
        win_tag  = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_idx  = PW'(i);
                win_tag  = bus.req_tag[i*tag_width +: tag_width];
                win_data = bus.req_data[i*data_width +: data_width];
            end
        end
    end

    // Boost mode rotates only over ALU grants; plain RR over every grant.
    assign rr_adv = (LDST_PRIO != 0) ? |gnt[NALU-1:0] : |gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cdb_q  <= '0;
            rr_ptr <= '0;
            streak <= '0;
        end else if (bus.flush) begin
            // Tag/data hold; only the broadcast is killed.
            cdb_q.valid <= 1'b0;
            rr_ptr      <= '0;
            streak      <= '0;
        end else begin
            if (|gnt) begin
                cdb_q.valid <= 1'b1;
                cdb_q.tag   <= lc3b_rob_addr'(win_tag);
                cdb_q.data  <= lc3b_word'(win_data);
            end else begin
                cdb_q.valid <= 1'b0;
            end

            if (rr_adv)
                rr_ptr <= (32'(win_idx) == RR_WRAP) ? '0 : win_idx + 1'b1;

            if (gnt[LDST])
                streak <= !others ? 2'd0 : (streak == 2'd3) ? 2'd3 : streak + 2'd1;
            else if (|gnt)
                streak <= 2'd0;
        end
    end

    assign bus.grant       = gnt;
    assign bus.cdb_out     = cdb_q;
    assign bus.ldst_streak = streak;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter (LDST_PRIO=1, LDST_LIMIT=2).
// Directed scenarios plus a randomized run, all checked against a
// transaction-level model of the arbitration rules.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_REQ(4), .tag_width(3), .data_width(16)) bus ();

    cdb_arbiter #(
        .NUM_REQ(4), .data_width(16), .tag_width(3),
        .LDST_PRIO(1), .LDST_LIMIT(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [2:0]  tags  [4];
    logic [15:0] datas [4];
    assign bus.req_tag  = {tags[3], tags[2], tags[1], tags[0]};
    assign bus.req_data = {datas[3], datas[2], datas[1], datas[0]};

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int   m_rr;
    int   m_streak;
    cdb_t m_cdb;

    function automatic int m_winner(logic [3:0] r, logic fl, logic rs);
        int k;
        if (rs || fl) return -1;
        if (r[3] && (m_streak < 2 || r[2:0] == 3'b000)) return 3;
        for (int off = 0; off < 3; off++) begin
            k = (m_rr + off) % 3;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [3:0] oh(int w);
        logic [3:0] v;
        v = '0;
        if (w >= 0) v[w] = 1'b1;
        return v;
    endfunction

    // Commit the current cycle into the model, then cross the clock edge.
    task automatic advance();
        int w;
        logic [3:0] r;
        r = bus.req;
        w = m_winner(r, bus.flush, reset);
        if (reset) begin
            m_rr = 0; m_streak = 0; m_cdb = '0;
        end else if (bus.flush) begin
            m_rr = 0; m_streak = 0; m_cdb.valid = 1'b0;
        end else if (w < 0) begin
            m_cdb.valid = 1'b0;
        end else begin
            m_cdb.valid = 1'b1;
            m_cdb.tag   = tags[w];
            m_cdb.data  = datas[w];
            if (w == 3) m_streak = (r[2:0] != 0) ? ((m_streak == 3) ? 3 : m_streak + 1) : 0;
            else begin m_rr = (w + 1) % 3; m_streak = 0; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.flush = 1'b0; bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) begin tags[i] = 3'(i + 1); datas[i] = 16'(i * 7); end
        for (int c = 0; c < 2; c++) begin
            #1;
            n_chk++;
            if (bus.grant !== 4'b0000) begin
                n_fail++; $display("FAIL reset_grant c%0d: got %b want 0000", c, bus.grant);
            end
            advance();
        end
        reset = 1'b0; bus.req = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_chk++;
            if (bus.grant !== 4'b0000 || bus.cdb_out !== '0 || bus.ldst_streak !== 2'd0) begin
                n_fail++; $display("FAIL reset_idle c%0d: grant %b cdb %h streak %0d want 0/0/0",
                                   c, bus.grant, bus.cdb_out, bus.ldst_streak);
            end
            advance();
        end
    endtask

    task automatic test_rr_sequence();
        logic [3:0] g;
        logic [3:0] exp_g [4];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b0000;
        bus.req = 4'b0111;
        tags[0] = 3'd1; tags[1] = 3'd2; tags[2] = 3'd3;
        datas[0] = 16'h0011; datas[1] = 16'h0022; datas[2] = 16'h0033;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_chk++;
            if (bus.grant !== exp_g[c]) begin
                n_fail++; $display("FAIL rr_grant c%0d: got %b want %b", c, bus.grant, exp_g[c]);
            end
            if (c > 0) begin
                n_chk++;
                if (bus.cdb_out !== {1'b1, 3'(c), 16'(c * 16'h0011)}) begin
                    n_fail++; $display("FAIL rr_cdb c%0d: got %h want tag %0d data %h",
                                       c, bus.cdb_out, c, 16'(c * 16'h0011));
                end
            end
            g = bus.grant;
            advance();
            bus.req = bus.req & ~g;
        end
    endtask

    task automatic test_ldst_boost();
        int exp_w [6];
        int exp_s [7];
        exp_w = '{3, 3, 0, 3, 3, 0};
        exp_s = '{0, 1, 2, 0, 1, 2, 0};
        reset = 1'b1; advance(); reset = 1'b0;
        bus.req = 4'b1001; tags[0] = 3'd5; datas[0] = 16'hBEEF;
        for (int c = 0; c < 7; c++) begin
            tags[3] = 3'(c); datas[3] = 16'h3000 + 16'(c);
            if (c == 6) bus.req = 4'b0000;
            #1;
            if (c < 6) begin
                n_chk++;
                if (bus.grant !== oh(exp_w[c])) begin
                    n_fail++; $display("FAIL boost_grant c%0d: got %b want %b", c, bus.grant, oh(exp_w[c]));
                end
            end
            n_chk++;
            if (bus.ldst_streak !== 2'(exp_s[c])) begin
                n_fail++; $display("FAIL boost_streak c%0d: got %0d want %0d", c, bus.ldst_streak, exp_s[c]);
            end
            if (c == 3) begin
                n_chk++;
                if (bus.cdb_out !== {1'b1, 3'd5, 16'hBEEF}) begin
                    n_fail++; $display("FAIL boost_cdb c%0d: got %h want valid tag 5 BEEF", c, bus.cdb_out);
                end
            end
            advance();
        end
    endtask

    task automatic test_ldst_only();
        reset = 1'b1; advance(); reset = 1'b0;
        bus.req = 4'b1000;
        for (int c = 0; c < 7; c++) begin
            tags[3] = 3'(c); datas[3] = 16'hA000 + 16'(c);
            if (c == 6) bus.req = 4'b0000;
            #1;
            n_chk++;
            if (bus.grant !== ((c < 6) ? 4'b1000 : 4'b0000) || bus.ldst_streak !== 2'd0) begin
                n_fail++; $display("FAIL ldst_only c%0d: grant %b streak %0d want %b/0",
                                   c, bus.grant, bus.ldst_streak, (c < 6) ? 4'b1000 : 4'b0000);
            end
            if (c > 0) begin
                n_chk++;
                if (bus.cdb_out !== {1'b1, 3'(c - 1), 16'hA000 + 16'(c - 1)}) begin
                    n_fail++; $display("FAIL ldst_only_cdb c%0d: got %h want tag %0d", c, bus.cdb_out, c - 1);
                end
            end
            advance();
        end
    endtask

    task automatic test_flush();
        reset = 1'b1; advance(); reset = 1'b0;
        bus.req = 4'b0010; tags[1] = 3'd4; datas[1] = 16'h4444;
        #1;
        n_chk++;
        if (bus.grant !== 4'b0010) begin
            n_fail++; $display("FAIL flush_pre_grant: got %b want 0010", bus.grant);
        end
        advance();
        bus.flush = 1'b1; bus.req = 4'b1101;
        #1;
        n_chk++;
        if (bus.grant !== 4'b0000 || bus.cdb_out !== {1'b1, 3'd4, 16'h4444}) begin
            n_fail++; $display("FAIL flush_cycle: grant %b cdb %h want 0000 / valid tag 4 4444",
                               bus.grant, bus.cdb_out);
        end
        advance();
        bus.flush = 1'b0; bus.req = 4'b0000;
        #1;
        n_chk++;
        if (bus.cdb_out.valid !== 1'b0 || bus.ldst_streak !== 2'd0) begin
            n_fail++; $display("FAIL flush_after: valid %b streak %0d want 0/0", bus.cdb_out.valid, bus.ldst_streak);
        end
        advance();
        // Pointer must be back at 0: requester 0 wins over 1 and 2.
        bus.req = 4'b0111;
        #1;
        n_chk++;
        if (bus.grant !== 4'b0001) begin
            n_fail++; $display("FAIL flush_rr_ptr: got %b want 0001", bus.grant);
        end
        advance();
        bus.req = 4'b0000;
    endtask

    task automatic test_reset_midstream();
        bus.req = 4'b0001; tags[0] = 3'd6; datas[0] = 16'h6666;
        #1;
        advance();
        reset = 1'b1; bus.req = 4'b1111;
        #1;
        n_chk++;
        if (bus.grant !== 4'b0000 || bus.cdb_out !== {1'b1, 3'd6, 16'h6666}) begin
            n_fail++; $display("FAIL rst_mid_pre: grant %b cdb %h want 0000 / valid tag 6 6666",
                               bus.grant, bus.cdb_out);
        end
        advance();
        #1;
        n_chk++;
        if (bus.grant !== 4'b0000 || bus.cdb_out !== '0 || bus.ldst_streak !== 2'd0) begin
            n_fail++; $display("FAIL rst_mid_post: grant %b cdb %h streak %0d want all 0",
                               bus.grant, bus.cdb_out, bus.ldst_streak);
        end
        reset = 1'b0; bus.req = 4'b0000;
        advance();
    endtask

    task automatic test_random();
        logic [3:0] g;
        logic       fl;
        reset = 1'b1; advance(); reset = 1'b0;
        for (int c = 0; c < 500; c++) begin
            bus.flush = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 59) == 0);
            #1;
            n_chk++;
            if (bus.grant !== oh(m_winner(bus.req, bus.flush, reset))) begin
                n_fail++; $display("FAIL rand_grant c%0d: req %b got %b want %b", c, bus.req,
                                   bus.grant, oh(m_winner(bus.req, bus.flush, reset)));
            end
            n_chk++;
            if (bus.cdb_out !== m_cdb) begin
                n_fail++; $display("FAIL rand_cdb c%0d: got %h want %h", c, bus.cdb_out, m_cdb);
            end
            n_chk++;
            if (bus.ldst_streak !== 2'(m_streak)) begin
                n_fail++; $display("FAIL rand_streak c%0d: got %0d want %0d", c, bus.ldst_streak, m_streak);
            end
            g  = bus.grant;
            fl = bus.flush;
            advance();
            // Hold an ungranted request stable; otherwise present something new.
            for (int i = 0; i < 4; i++) begin
                if (fl) begin
                    bus.req[i] = 1'b0;
                end else if (!bus.req[i] || g[i]) begin
                    bus.req[i] = ($urandom_range(0, 2) != 0);
                    tags[i]    = 3'($urandom);
                    datas[i]   = 16'($urandom);
                end
            end
        end
        reset = 1'b0; bus.flush = 1'b0; bus.req = 4'b0000;
    endtask

    initial begin
        reset = 1'b1; bus.flush = 1'b0; bus.req = 4'b0000;
        for (int i = 0; i < 4; i++) begin tags[i] = '0; datas[i] = '0; end
        m_rr = 0; m_streak = 0; m_cdb = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_rr_sequence();
        test_ldst_boost();
        test_ldst_only();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
